// File: rtl/shift_pkg.sv
// Shared constants for the multi-cycle shift unit: op codes, FSM states, default widths.
package shift_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SHAMT_W = 5;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Codes above ROL are pass-through: they never shift, whatever shamt says.
   function automatic logic is_pass(input logic [2:0] op);
      return (op > OP_ROL);
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a value by 1 or 4 bit positions for the given op.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic [2:0]       i_op,
   input  logic [2:0]       i_stride,
   output logic [WIDTH-1:0] o_value
);

   logic w_s4;
   assign w_s4 = (i_stride == 3'd4);

   // Any stride other than 4 is treated as a single-bit step.
   always_comb begin
      o_value = i_value;
      case (i_op)
         OP_SLL: begin
            if (w_s4) o_value = {i_value[WIDTH-5:0], 4'b0000};
            else      o_value = {i_value[WIDTH-2:0], 1'b0};
         end
         OP_SRL: begin
            if (w_s4) o_value = {4'b0000, i_value[WIDTH-1:4]};
            else      o_value = {1'b0, i_value[WIDTH-1:1]};
         end
         OP_SRA: begin
            if (w_s4) o_value = {{4{i_value[WIDTH-1]}}, i_value[WIDTH-1:4]};
            else      o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
         end
         OP_ROR: begin
            if (w_s4) o_value = {i_value[3:0], i_value[WIDTH-1:4]};
            else      o_value = {i_value[0], i_value[WIDTH-1:1]};
         end
         OP_ROL: begin
            if (w_s4) o_value = {i_value[WIDTH-5:0], i_value[WIDTH-1:WIDTH-4]};
            else      o_value = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
         end
         default: o_value = i_value;
      endcase
   end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit with start/busy/done handshake.
// Optional SHIFT_STRIDE4_EN: consume 4 bit positions per cycle while at least 4 remain.
module shift_unit_seq
   import shift_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = DEF_SHAMT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   data_out
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_data;
   logic [WIDTH-1:0]     w_step;
   logic [SHAMT_W-1:0]   r_cnt;
   logic [SHAMT_W-1:0]   w_cnt_dec;
   logic [SHAMT_W-1:0]   w_shamt_eff;
   logic [2:0]           r_op;
   logic [2:0]           w_stride;
   logic                 w_use4;
   logic                 r_busy;
   logic                 r_done;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;

`ifdef SHIFT_STRIDE4_EN
   assign w_use4   = (r_cnt >= SHAMT_W'(4));
   assign w_stride = w_use4 ? 3'd4 : 3'd1;
`else
   assign w_use4   = 1'b0;
   assign w_stride = 3'd1;
`endif

   assign w_cnt_dec   = r_cnt - (w_use4 ? SHAMT_W'(4) : SHAMT_W'(1));
   assign w_shamt_eff = is_pass(op) ? {SHAMT_W{1'b0}} : shamt;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .i_value  (r_data),
      .i_op     (r_op),
      .i_stride (w_stride),
      .o_value  (w_step)
   );

   // State register; busy/done are registered from the next state so they never see inputs combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_shamt_eff != {SHAMT_W{1'b0}}) w_state_nxt = ST_SHIFT;
               else                                w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (w_cnt_dec == {SHAMT_W{1'b0}}) w_state_nxt = ST_DONE;
            else                              w_state_nxt = ST_SHIFT;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode of the upcoming state.
   always_comb begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      if (w_state_nxt == ST_IDLE) begin
         w_busy_nxt = 1'b0;
         w_done_nxt = 1'b0;
      end else begin
         w_busy_nxt = 1'b1;
         w_done_nxt = (w_state_nxt == ST_DONE);
      end
   end

   // Shift register, remaining count and latched op.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= {WIDTH{1'b0}};
         r_cnt  <= {SHAMT_W{1'b0}};
         r_op   <= OP_SLL;
      end else if ((r_state == ST_IDLE) && start) begin
         r_data <= data_in;
         r_cnt  <= w_shamt_eff;
         r_op   <= op;
      end else if (r_state == ST_SHIFT) begin
         r_data <= w_step;
         r_cnt  <= w_cnt_dec;
      end else begin
         r_data <= r_data;
         r_cnt  <= r_cnt;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign data_out = r_data;

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Multi-cycle shift/rotate unit for the multicycle CPU datapath.
- Sits downstream of the shift-amount and shift-source selection muxes and consumes the 5-bit shift amount they produce.
- Performs one bit-step per clock under control-unit handshake (start/busy/done) and holds the result for write-back.

Parameters:
- WIDTH, 32, data path width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code, sampled with start.
- data_in  in  WIDTH  operand, sampled with start.
- shamt  in  SHAMT_W  shift amount, sampled with start.
- busy  out  1  high in SHIFT and DONE states.
- done  out  1  one-cycle pulse; result valid.
- data_out  out  WIDTH  internal shift register; final value held until next accepted start.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE, data_out=0, counter=0, busy=0, done=0.
  - Reset mid-operation aborts the operation with no done pulse.
- op encoding:
  - 000 SLL: zero fill.
  - 001 SRL: zero fill.
  - 010 SRA: sign fill from bit WIDTH-1.
  - 011 ROR.
  - 100 ROL.
  - 101–111 PASS: no shift; shamt ignored and treated as 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1 at an edge: load reg<=data_in, cnt<=shamt, op_r<=op.
  - Next state is SHIFT if the effective shamt is nonzero, else DONE.
  - start=0: remain in IDLE; data_out holds.
- SHIFT:
  - Each edge: reg<=step(reg, op_r), cnt<=cnt-1.
  - When cnt==1 at the edge, next state is DONE.
- DONE:
  - done=1 for exactly this cycle; busy=1.
  - Next edge: IDLE, unconditionally.
- Latency:
  - Start sampled at edge E0; done is high in the cycle after edge E0+shamt.
  - Total is shamt+1 cycles from the start cycle.
  - shamt=0 gives done in the cycle immediately after start.
- start while busy (SHIFT or DONE): ignored, not queued.
  - Back-to-back operation: start may be reasserted in the first IDLE cycle after DONE.
- data_out is the live register:
  - Intermediate values are visible during SHIFT.
  - Consumers capture only on done or later.
  - The value holds in IDLE until the next accepted start.
- shamt=31: 31 single steps.
  - SLL of 1 yields 0x80000000.
  - SRA of 0x80000000 yields 0xFFFFFFFF.
- busy and done are registered decodes of state; neither has a combinational path from any input.

Optional Feature:
- Macro: SHIFT_STRIDE4_EN.
- Defined:
  - In SHIFT, when cnt>=4, reg<=step4(reg, op_r) and cnt<=cnt-4; otherwise the single step applies.
  - Transition to DONE occurs when the step brings cnt to 0.
  - Latency = floor(shamt/4) + (shamt mod 4) + 1 cycles.
- Undefined: one bit per cycle only; latency = shamt+1.
- Results are bit-identical in both builds.

Decomposition:
- Package shift_pkg:
  - op codes (OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL).
  - state encoding (ST_IDLE, ST_SHIFT, ST_DONE).
  - Width constants WIDTH/SHAMT_W defaults.
- Sub-module shift_step (purely combinational):
  - Inputs: value, op, stride (1 or 4).
  - Output: shifted value.
  - Instantiated once; the stride input is tied to 1 when SHIFT_STRIDE4_EN is undefined.
- The FSM, counter and register stay in shift_unit_seq.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → data_out=0, busy=0, done=0; no done while start=0.
- SLL basic: start, op=000, data_in=0x00000001, shamt=4 → done in cycle 5 after start, data_out=0x00000010; busy high cycles 1–5.
- SRA sign fill: op=010, data_in=0x80000000, shamt=31 → data_out=0xFFFFFFFF, done at cycle 32 (stride build: cycle 11).
- Rotate and zero shamt:
  - op=011, data_in=0x0000000F, shamt=4 → 0xF0000000.
  - op=100, shamt=0 → done at cycle 1, data_out=data_in.
- Ignored start and back-to-back:
  - Pulse start with different operands during SHIFT → result unaffected.
  - Start in the first IDLE cycle after done → accepted.
- Reset mid-operation: reset asserted during SHIFT of shamt=20 → next cycle IDLE, data_out=0, no done pulse; a following op=001, data_in=0xF0000000, shamt=28 yields 0x0000000F.
